sha2_pad_ctrl: RTL and testbench
================================

Name: sha2_pad_ctrl

Overview:
- Sequencer for the SHA-2 input datapath (64-bit packet store, 8-entry block regfile, message-length accumulator).
- Accepts a stream of 64-bit message words and drives st_pkt/clr/pad_pkt/zero_pkt/mgln_pkt so each 512-bit block is filled, padded and length-terminated.
- Presents each completed block to the compression stage with a valid/ack handshake, stalling the datapath while a block is pending.

Parameters:
reg_cnt, 8, words per block; must equal 2**dec_w
dec_w, 3, width of the word index; matches the datapath index width

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
pkt_valid  input  1  message word present on the datapath pkt bus
pkt_last  input  1  qualifies pkt_valid; the word is the final message word
pkt_ready  output  1  controller accepts a message word this cycle
abort  input  1  synchronous: discard the current message
blk_ack  input  1  consumer has taken the pending block
blk_valid  output  1  regfile holds a complete block
blk_last  output  1  qualifies blk_valid; the block is the final block of the message
msg_done  output  1  one-cycle pulse when the final block is acked
st_pkt  output  1  datapath store strobe
clr  output  1  datapath clear (index and length)
pad_pkt  output  1  select pad word 0x8000_0000_0000_0000
zero_pkt  output  1  select zero word
mgln_pkt  output  1  select message length (bits)
idx  output  dec_w  internal word index; mirrors the datapath index

Behaviour:
- Reset: state=MSG, idx=0, ret=MSG, fin=0. All strobes, pkt_ready, blk_valid, blk_last and msg_done are 0 except pkt_ready, which is 1 because the state is MSG.
- The state register, idx and ret/fin are the only flops. All outputs decode combinationally from state and inputs.
- idx increments, and wraps modulo reg_cnt, on every cycle with st_pkt=1.
- idx is cleared in any cycle with clr=1.
- st_pkt and clr are never asserted in the same cycle.
- At most one of pad_pkt/zero_pkt/mgln_pkt is high, and only together with st_pkt.
- States: MSG, PAD, ZERO, LEN, FULL.
- MSG:
  - pkt_ready=1; st_pkt=pkt_valid.
  - On a store with idx==reg_cnt-1: go to FULL with ret=PAD if pkt_last, otherwise ret=MSG.
  - Otherwise, on a store with pkt_last: go to PAD.
- PAD:
  - st_pkt=pad_pkt=1 for one cycle.
  - If idx==reg_cnt-1: go to FULL with ret=ZERO.
  - Else if idx==reg_cnt-2: go to LEN.
  - Else: go to ZERO.
- ZERO: st_pkt=zero_pkt=1 each cycle; go to LEN after the store at idx==reg_cnt-2.
- LEN: st_pkt=mgln_pkt=1 at idx==reg_cnt-1; go to FULL with fin=1.
- FULL:
  - blk_valid=1; blk_last=fin; no strobes; pkt_ready=0.
  - On blk_ack with fin=0: go to ret.
  - On blk_ack with fin=1: assert clr and msg_done in that cycle, set fin=0, go to MSG.
- blk_valid remains asserted until acked. blk_ack outside FULL is ignored.
- Length accounting: the datapath adds 64 per plain message store, so the length word equals 64 × (message words).
- Zero-length messages are not supported; pkt_last is only meaningful with pkt_valid.
- abort:
  - Highest priority in every state.
  - Assert clr for that cycle, suppress st_pkt, drop blk_valid, go to MSG, fin=0, no msg_done.
- Reset mid-operation: returns to the reset state immediately. The datapath resets in the same event.
- Throughput: 1 word per cycle in MSG/PAD/ZERO/LEN. A block is presented in the cycle after its 8th store.

Decomposition:
- Shared package: state enum (MSG, PAD, ZERO, LEN, FULL), PAD_WORD=64'h8000_0000_0000_0000, BITS_PER_WORD=64.
- The controller and the existing datapath are wired together in a separate integration top.
- The idx mirror is the existing cntr sub-module (c_up=st_pkt, clr=clr). No other sub-module.

Test Plan:
- 1-word message, blk_ack immediate: word at idx0, pad idx1, zeros idx2-6, length idx7=0x40. One blk_valid with blk_last=1, msg_done pulse, clr=1 in the same cycle, then idx=0.
- 7-word message: words idx0-6, pad idx7, block1 blk_last=0. After ack, zeros idx0-6 and length=0x1C0 at idx7; block2 blk_last=1.
- 8-word message: block1 is all data with blk_last=0. Block2 has pad at idx0, zeros idx1-6, length=0x200 at idx7.
- Backpressure: blk_ack held low 5 cycles in FULL with pkt_valid=1. pkt_ready=0 and no st_pkt for 5 cycles; blk_valid stable; the stream resumes on the ack cycle+1.
- abort after 3 words: clr=1 and idx=0 next cycle, no blk_valid, no msg_done. A following 1-word message yields length 0x40, not 0x100.
- rst_b low during ZERO: all outputs return to reset values asynchronously; a new 1-word message after release completes normally.

Source files
------------

// File: rtl/sha2_pad_ctrl_pkg.sv
// rtl/sha2_pad_ctrl_pkg.sv - shared types and constants for the SHA-2 padding sequencer
//
// Purpose: controller state encoding plus the constant words the datapath
//          selects when the controller raises pad_pkt / mgln_pkt.
// Ports:   none (package).
package sha2_pad_ctrl_pkg;

  typedef enum logic [2:0] {
    MSG  = 3'd0,
    PAD  = 3'd1,
    ZERO = 3'd2,
    LEN  = 3'd3,
    FULL = 3'd4
  } state_e;

  localparam logic [63:0] PAD_WORD      = 64'h8000_0000_0000_0000;
  localparam int          BITS_PER_WORD = 64;

endpackage

// File: rtl/sha2_pad_ctrl_cntr.sv
// rtl/sha2_pad_ctrl_cntr.sv - word index counter mirroring the datapath index
//
// Purpose: counts stores into the block regfile, wrapping modulo 2**dec_w.
// Ports:   clk, rst_b (async active-low), i_c_up (count up), i_clr (clear,
//          dominant), o_cnt (current index).
module sha2_pad_ctrl_cntr #(
  parameter int dec_w = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_c_up,
  input  logic             i_clr,
  output logic [dec_w-1:0] o_cnt
);

  logic [dec_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_c_up) begin
      r_cnt <= r_cnt + 1'b1;  // natural wrap at 2**dec_w
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sha2_pad_ctrl.sv
// rtl/sha2_pad_ctrl.sv - sequencer filling, padding and length-terminating SHA-2 blocks
//
// Purpose: accepts 64-bit message words, drives the datapath store/select
//          strobes so each 512-bit block is completed, and hands finished
//          blocks to the compression stage with a valid/ack handshake.
// Ports:   clk, rst_b (async active-low)
//          pkt_valid/pkt_last/pkt_ready - message word stream
//          abort                        - discard current message
//          blk_valid/blk_last/blk_ack   - block handshake, msg_done pulse
//          st_pkt/clr/pad_pkt/zero_pkt/mgln_pkt - datapath strobes
//          idx                          - word index (mirror of datapath)
module sha2_pad_ctrl
  import sha2_pad_ctrl_pkg::*;
#(
  parameter int reg_cnt = 8,
  parameter int dec_w   = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             pkt_valid,
  input  logic             pkt_last,
  output logic             pkt_ready,
  input  logic             abort,
  input  logic             blk_ack,
  output logic             blk_valid,
  output logic             blk_last,
  output logic             msg_done,
  output logic             st_pkt,
  output logic             clr,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             mgln_pkt,
  output logic [dec_w-1:0] idx
);

  localparam logic [dec_w-1:0] LAST_IDX   = dec_w'(reg_cnt - 1);
  localparam logic [dec_w-1:0] PENULT_IDX = dec_w'(reg_cnt - 2);

  state_e r_state, w_nxt_state;
  state_e r_ret,   w_nxt_ret;     // state to resume after a non-final block is acked
  logic   r_fin,   w_nxt_fin;     // pending block carries the length word

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= MSG;
      r_ret   <= MSG;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ret   <= w_nxt_ret;
      r_fin   <= w_nxt_fin;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_nxt_fin   = r_fin;
    pkt_ready   = 1'b0;
    st_pkt      = 1'b0;
    clr         = 1'b0;
    pad_pkt     = 1'b0;
    zero_pkt    = 1'b0;
    mgln_pkt    = 1'b0;
    blk_valid   = 1'b0;
    blk_last    = 1'b0;
    msg_done    = 1'b0;

    if (abort) begin
      clr         = 1'b1;
      w_nxt_state = MSG;
      w_nxt_fin   = 1'b0;
    end else begin
      unique case (r_state)
        MSG: begin
          pkt_ready = 1'b1;
          st_pkt    = pkt_valid;
          if (pkt_valid) begin
            if (idx == LAST_IDX) begin
              // Block filled by data; padding (if any) starts the next block.
              w_nxt_state = FULL;
              w_nxt_ret   = pkt_last ? PAD : MSG;
            end else if (pkt_last) begin
              w_nxt_state = PAD;
            end
          end
        end
        PAD: begin
          st_pkt  = 1'b1;
          pad_pkt = 1'b1;
          if (idx == LAST_IDX) begin
            // No room left for the length word: it goes in an extra block.
            w_nxt_state = FULL;
            w_nxt_ret   = ZERO;
          end else if (idx == PENULT_IDX) begin
            w_nxt_state = LEN;
          end else begin
            w_nxt_state = ZERO;
          end
        end
        ZERO: begin
          st_pkt   = 1'b1;
          zero_pkt = 1'b1;
          if (idx == PENULT_IDX) begin
            w_nxt_state = LEN;
          end
        end
        LEN: begin
          st_pkt      = 1'b1;
          mgln_pkt    = 1'b1;
          w_nxt_state = FULL;
          w_nxt_fin   = 1'b1;
        end
        FULL: begin
          blk_valid = 1'b1;
          blk_last  = r_fin;
          if (blk_ack) begin
            if (r_fin) begin
              clr         = 1'b1;
              msg_done    = 1'b1;
              w_nxt_fin   = 1'b0;
              w_nxt_state = MSG;
            end else begin
              w_nxt_state = r_ret;
            end
          end
        end
        default: begin
          w_nxt_state = MSG;
        end
      endcase
    end
  end

  sha2_pad_ctrl_cntr #(
    .dec_w (dec_w)
  ) u_idx (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_c_up (st_pkt),
    .i_clr  (clr),
    .o_cnt  (idx)
  );

endmodule

// File: tb/tb_sha2_pad_ctrl.sv
// tb/tb_sha2_pad_ctrl.sv - self-checking bench for sha2_pad_ctrl
module tb_sha2_pad_ctrl;
  import sha2_pad_ctrl_pkg::*;

  logic       clk;
  logic       rst_b;
  logic       pkt_valid;
  logic       pkt_last;
  logic       pkt_ready;
  logic       abort;
  logic       blk_ack;
  logic       blk_valid;
  logic       blk_last;
  logic       msg_done;
  logic       st_pkt;
  logic       clr;
  logic       pad_pkt;
  logic       zero_pkt;
  logic       mgln_pkt;
  logic [2:0] idx;

  logic [63:0] pkt_data;

  int checks = 0;
  int errors = 0;

  sha2_pad_ctrl dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .pkt_valid (pkt_valid),
    .pkt_last  (pkt_last),
    .pkt_ready (pkt_ready),
    .abort     (abort),
    .blk_ack   (blk_ack),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .msg_done  (msg_done),
    .st_pkt    (st_pkt),
    .clr       (clr),
    .pad_pkt   (pad_pkt),
    .zero_pkt  (zero_pkt),
    .mgln_pkt  (mgln_pkt),
    .idx       (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: packet store into an 8-entry regfile plus length accumulator.
  logic [63:0] m_mem [8];
  logic [2:0]  m_idx;
  logic [63:0] m_len;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_idx <= '0;
      m_len <= '0;
      for (int i = 0; i < 8; i++) m_mem[i] <= '0;
    end else if (clr) begin
      m_idx <= '0;
      m_len <= '0;
    end else if (st_pkt) begin
      if (pad_pkt)       m_mem[m_idx] <= PAD_WORD;
      else if (zero_pkt) m_mem[m_idx] <= '0;
      else if (mgln_pkt) m_mem[m_idx] <= m_len;
      else begin
        m_mem[m_idx] <= pkt_data;
        m_len        <= m_len + 64'(BITS_PER_WORD);
      end
      m_idx <= m_idx + 3'd1;
    end
  end

  function automatic logic [63:0] pat(input int w);
    return 64'hA5A5_0000_0000_0000 | 64'(w);
  endfunction

  function automatic logic [11:0] outs();
    return {pkt_ready, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt,
            blk_valid, blk_last, msg_done, idx};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  in;   // {pkt_valid, pkt_last, abort, blk_ack}
    logic [11:0] exp;  // {rdy, st, clr, pad, zero, mgln, bv, bl, md, idx[2:0]}
  } vec_t;

  vec_t tbl [12];

  logic [63:0] blk_mem  [4][8];
  logic        blk_lastq[4];
  int          nblk;

  task automatic check_blk(input int b, input logic [63:0] e [8], input logic el, input string nm);
    int bad;
    bad = -1;
    for (int i = 7; i >= 0; i--) if (blk_mem[b][i] !== e[i]) bad = i;
    if (bad < 0) chk(blk_lastq[b] === el, {nm, " blk_last"}, 64'(blk_lastq[b]), 64'(el));
    else chk(1'b0, $sformatf("%s word%0d", nm, bad), blk_mem[b][bad], e[bad]);
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    abort     = 1'b0;
    blk_ack   = 1'b0;
  endtask

  // Streams an n-word message, acking each block ack_dly cycles after it appears.
  task automatic run_msg(input int n, input int ack_dly, input string nm);
    int  w;
    int  wait_c;
    bit  done;
    bit  resume_chk;
    nblk       = 0;
    w          = 0;
    wait_c     = 0;
    done       = 1'b0;
    resume_chk = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      idle_inputs();
      pkt_valid = (w < n);
      pkt_last  = (w == n - 1);
      pkt_data  = pat(w);
      #2;
      if (resume_chk) begin
        chk(st_pkt === 1'b1 && idx === 3'd0, {nm, " resume"}, 64'({st_pkt, idx}), 64'({1'b1, 3'd0}));
        resume_chk = 1'b0;
      end
      if (blk_valid) begin
        if (wait_c == 0 && nblk < 4) begin
          for (int i = 0; i < 8; i++) blk_mem[nblk][i] = m_mem[i];
          blk_lastq[nblk] = blk_last;
        end
        if (wait_c < ack_dly) begin
          if (pkt_valid)
            chk(pkt_ready === 1'b0 && st_pkt === 1'b0, {nm, " stall"},
                64'({pkt_ready, st_pkt}), 64'(0));
          wait_c++;
        end else begin
          blk_ack = 1'b1;
          #1;
          if (blk_last) begin
            chk(msg_done === 1'b1 && clr === 1'b1, {nm, " msg_done"},
                64'({msg_done, clr}), 64'(2'b11));
            done = 1'b1;
          end else if (pkt_valid) begin
            resume_chk = 1'b1;
          end
          nblk++;
          wait_c = 0;
        end
      end else if (pkt_ready && pkt_valid) begin
        w++;
      end
    end
    chk(done, {nm, " completed"}, 64'(done), 64'(1));
    @(negedge clk);
    idle_inputs();
    #2;
    chk(idx === 3'd0 && blk_valid === 1'b0, {nm, " idle after"}, 64'({blk_valid, idx}), 64'(0));
  endtask

  function automatic vec_t mk(input logic [3:0] in, input logic [11:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  logic [63:0] e [8];

  initial begin
    idle_inputs();
    pkt_data = '0;
    rst_b    = 1'b0;
    #12;
    chk(outs() === 12'b1000_0000_0000, "reset state", 64'(outs()), 64'(12'b1000_0000_0000));
    @(negedge clk);
    rst_b = 1'b1;

    // 1-word message, immediate ack, cycle by cycle.
    tbl[0]  = mk(4'b0000, 12'b1_0_0_0_0_0_0_0_0_000);
    tbl[1]  = mk(4'b1100, 12'b1_1_0_0_0_0_0_0_0_000);
    tbl[2]  = mk(4'b0000, 12'b0_1_0_1_0_0_0_0_0_001);
    tbl[3]  = mk(4'b0000, 12'b0_1_0_0_1_0_0_0_0_010);
    tbl[4]  = mk(4'b0000, 12'b0_1_0_0_1_0_0_0_0_011);
    tbl[5]  = mk(4'b0000, 12'b0_1_0_0_1_0_0_0_0_100);
    tbl[6]  = mk(4'b0000, 12'b0_1_0_0_1_0_0_0_0_101);
    tbl[7]  = mk(4'b0000, 12'b0_1_0_0_1_0_0_0_0_110);
    tbl[8]  = mk(4'b0000, 12'b0_1_0_0_0_1_0_0_0_111);
    tbl[9]  = mk(4'b0001, 12'b0_0_1_0_0_0_1_1_1_000);
    tbl[10] = mk(4'b0000, 12'b1_0_0_0_0_0_0_0_0_000);
    tbl[11] = mk(4'b0001, 12'b1_0_0_0_0_0_0_0_0_000);
    pkt_data = pat(0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      {pkt_valid, pkt_last, abort, blk_ack} = tbl[i].in;
      #2;
      chk(outs() === tbl[i].exp, $sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end
    idle_inputs();
    e = '{pat(0), PAD_WORD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h40};
    begin
      int bad;
      bad = -1;
      for (int i = 7; i >= 0; i--) if (m_mem[i] !== e[i]) bad = i;
      if (bad < 0) chk(1'b1, "1word block", 64'd0, 64'd0);
      else chk(1'b0, $sformatf("1word block word%0d", bad), m_mem[bad], e[bad]);
    end

    // 7-word message: pad lands at idx7, length needs a second block.
    run_msg(7, 0, "7word");
    chk(nblk == 2, "7word nblk", 64'(nblk), 64'd2);
    e = '{pat(0), pat(1), pat(2), pat(3), pat(4), pat(5), pat(6), PAD_WORD};
    check_blk(0, e, 1'b0, "7word b0");
    e = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h1C0};
    check_blk(1, e, 1'b1, "7word b1");

    // 8-word message: first block all data, padding starts block 2.
    run_msg(8, 0, "8word");
    chk(nblk == 2, "8word nblk", 64'(nblk), 64'd2);
    e = '{pat(0), pat(1), pat(2), pat(3), pat(4), pat(5), pat(6), pat(7)};
    check_blk(0, e, 1'b0, "8word b0");
    e = '{PAD_WORD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h200};
    check_blk(1, e, 1'b1, "8word b1");

    // Backpressure: 10 words, each block held 5 cycles before ack.
    run_msg(10, 5, "bp");
    chk(nblk == 2, "bp nblk", 64'(nblk), 64'd2);
    e = '{pat(0), pat(1), pat(2), pat(3), pat(4), pat(5), pat(6), pat(7)};
    check_blk(0, e, 1'b0, "bp b0");
    e = '{pat(8), pat(9), PAD_WORD, 64'd0, 64'd0, 64'd0, 64'd0, 64'h280};
    check_blk(1, e, 1'b1, "bp b1");

    // Abort after 3 words.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      pkt_valid = 1'b1;
      pkt_data  = pat(10 + i);
    end
    @(negedge clk);
    idle_inputs();
    pkt_valid = 1'b1;
    abort     = 1'b1;
    #2;
    chk({clr, st_pkt, blk_valid, msg_done} === 4'b1000, "abort strobes",
        64'({clr, st_pkt, blk_valid, msg_done}), 64'(4'b1000));
    @(negedge clk);
    idle_inputs();
    #2;
    chk(idx === 3'd0 && blk_valid === 1'b0 && msg_done === 1'b0, "abort idx",
        64'({blk_valid, msg_done, idx}), 64'(0));
    run_msg(1, 0, "post-abort");
    e = '{pat(0), PAD_WORD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h40};
    check_blk(0, e, 1'b1, "post-abort b0");

    // Reset asserted while padding with zeros.
    @(negedge clk);
    idle_inputs();
    pkt_valid = 1'b1;
    pkt_last  = 1'b1;
    pkt_data  = pat(0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        idle_inputs();
        #2;
        seen = zero_pkt;
      end
      chk(seen, "reach ZERO", 64'(seen), 64'd1);
    end
    rst_b = 1'b0;
    #1;
    chk(outs() === 12'b1000_0000_0000, "async reset", 64'(outs()), 64'(12'b1000_0000_0000));
    @(negedge clk);
    rst_b = 1'b1;
    run_msg(1, 0, "post-reset");
    e = '{pat(0), PAD_WORD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h40};
    check_blk(0, e, 1'b1, "post-reset b0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
